// File: rtl/sm4_pkg.sv
// Shared SM4 constants and round-function helpers for the pipelined cipher core.
// T = L(tau(x)) is the data-path round transform; the key schedule lives elsewhere.
package sm4_pkg;

  localparam int BLK_W   = 128;
  localparam int RK_W    = 1024;
  localparam int NROUNDS = 32;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] sbox32(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Linear diffusion L(b) = b ^ rol2 ^ rol10 ^ rol18 ^ rol24.
  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
           {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  function automatic logic [31:0] sm4_t(input logic [31:0] x);
    return l_enc(sbox32(x));
  endfunction

endpackage

// File: rtl/sm4_round.sv
// One combinational SM4 round: {A,B,C,D} -> {B,C,D, A ^ T(B^C^D^K)}.
module sm4_round
  import sm4_pkg::*;
(
  input  logic [BLK_W-1:0] state_in,
  input  logic [31:0]      rk_in,
  output logic [BLK_W-1:0] state_out
);

  logic [31:0] new_word;

  assign new_word  = state_in[127:96] ^
                     sm4_t(state_in[95:64] ^ state_in[63:32] ^ state_in[31:0] ^ rk_in);
  assign state_out = {state_in[95:0], new_word};

endmodule

// File: rtl/sm4_pipe_core.sv
// Pipelined SM4 encrypt/decrypt core with RPS rounds per stage, per-beat mode/tag,
// valid/ready handshake with a global stall, and the final word reversal R.
module sm4_pipe_core
  import sm4_pkg::*;
#(
  parameter int RPS   = 1,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_dec,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [RK_W-1:0]  rk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_dec,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = NROUNDS / RPS;

  if ((RPS < 1) || (RPS > NROUNDS) || ((NROUNDS % RPS) != 0)) begin : g_bad_rps
    $error("sm4_pipe_core: RPS must divide 32");
  end

  logic             vld_q [0:STAGES];
  logic             dec_q [0:STAGES];
  logic [TAG_W-1:0] tag_q [0:STAGES];
  logic [BLK_W-1:0] st_q  [0:STAGES];
  logic [BLK_W-1:0] nxt   [1:STAGES];
  logic             adv;

  // The whole pipe moves in lockstep; a held output freezes every stage.
  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;

  // Each stage picks its keys from its own dec bit so mixed-mode beats can interleave.
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic [BLK_W-1:0] chain [0:RPS];
    assign chain[0] = st_q[k-1];
    for (genvar j = 0; j < RPS; j++) begin : g_round
      localparam int R = (k - 1) * RPS + j;
      logic [31:0] rk_sel;
      assign rk_sel = dec_q[k-1] ? rk[32*R +: 32] : rk[RK_W-1-32*R -: 32];
      sm4_round u_round (
        .state_in (chain[j]),
        .rk_in    (rk_sel),
        .state_out(chain[j+1])
      );
    end
    assign nxt[k] = chain[RPS];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i <= STAGES; i++) begin
        vld_q[i] <= 1'b0;
        dec_q[i] <= 1'b0;
        tag_q[i] <= '0;
        st_q[i]  <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      dec_q[0] <= in_dec;
      tag_q[0] <= in_tag;
      st_q[0]  <= in_data;
      for (int i = 1; i <= STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        dec_q[i] <= dec_q[i-1];
        tag_q[i] <= tag_q[i-1];
        st_q[i]  <= nxt[i];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign out_dec   = dec_q[STAGES];
  assign out_tag   = tag_q[STAGES];
  assign out_data  = {st_q[STAGES][31:0], st_q[STAGES][63:32],
                      st_q[STAGES][95:64], st_q[STAGES][127:96]};

endmodule
